// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the fetch PC, issues single outstanding reads to
// instruction memory and buffers returned words (tagged with PC) for decode.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_ack,
  input  logic [15:0] imem_data,
  output logic        inst_valid,
  output logic [15:0] inst,
  output logic [15:0] inst_pc,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        hlt
);

  localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;
  localparam logic [15:0] RST_PC_EVEN = RESET_PC & 16'hFFFE;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_HALT} state_t;

  state_t          r_state, w_state_nxt;
  logic [15:0]     r_fetch_pc, w_fetch_pc_nxt;
  logic [15:0]     r_addr;
  logic            r_squash, w_squash_nxt;
  logic [15:0]     r_buf_inst [BUF_DEPTH];
  logic [15:0]     r_buf_pc   [BUF_DEPTH];
  logic [PW-1:0]   r_head, r_tail;
  logic [CW-1:0]   r_count, w_cnt_after;
  logic            w_push, w_pop, w_flush, w_full, w_outstanding;
  logic [15:0]     w_redirect_pc;

  assign w_outstanding = (r_state == S_FETCH) || (r_state == S_DRAIN);
  assign w_full        = (r_count == CW'(BUF_DEPTH));
  assign w_redirect_pc = redirect_pc & 16'hFFFE;

  assign inst_valid = (r_count != '0) && (r_state != S_HALT);
  assign inst       = r_buf_inst[r_head];
  assign inst_pc    = r_buf_pc[r_head];
  assign imem_req   = w_outstanding;
  assign imem_addr  = r_addr;

  assign w_pop       = inst_valid & inst_ready;
  assign w_cnt_after = r_count + CW'(1) - CW'(w_pop);

  always_comb begin
    w_state_nxt    = r_state;
    w_fetch_pc_nxt = r_fetch_pc;
    w_squash_nxt   = r_squash;
    w_push         = 1'b0;
    w_flush        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (hlt) begin
          w_flush     = 1'b1;
          w_state_nxt = S_HALT;
        end else if (redirect_valid) begin
          w_flush        = 1'b1;
          w_fetch_pc_nxt = w_redirect_pc;
          w_state_nxt    = S_FETCH;
        end else if (!w_full) begin
          w_state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        if (hlt) begin
          w_flush      = 1'b1;
          w_squash_nxt = 1'b0;
          w_state_nxt  = imem_ack ? S_HALT : S_DRAIN;
        end else if (redirect_valid) begin
          // An unacked request stays on the bus; its data is dropped via squash.
          w_flush        = 1'b1;
          w_fetch_pc_nxt = w_redirect_pc;
          w_squash_nxt   = !imem_ack;
        end else if (imem_ack) begin
          if (r_squash) begin
            w_squash_nxt = 1'b0;
          end else begin
            w_push         = 1'b1;
            w_fetch_pc_nxt = r_fetch_pc + 16'd2;
            if (w_cnt_after == CW'(BUF_DEPTH)) w_state_nxt = S_IDLE;
          end
        end
      end
      S_DRAIN: begin
        if (imem_ack) begin
          w_squash_nxt = 1'b0;
          w_state_nxt  = S_HALT;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_fetch_pc <= RST_PC_EVEN;
      r_addr     <= RST_PC_EVEN;
      r_squash   <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_fetch_pc <= w_fetch_pc_nxt;
      r_squash   <= w_squash_nxt;
      if (!(w_outstanding && !imem_ack)) r_addr <= w_fetch_pc_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
        r_buf_inst[i] <= '0;
        r_buf_pc[i]   <= '0;
      end
    end else if (w_flush) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_buf_inst[r_tail] <= imem_data;
        r_buf_pc[r_tail]   <= r_fetch_pc;
        r_tail             <= r_tail + PW'(1);
      end
      if (w_pop) r_head <= r_head + PW'(1);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

endmodule
